// File: rtl/lbm_dist_bank.sv
`default_nettype none
// ============================================================================
//  Module      : lbm_dist_bank
//  Description : Double-buffered (ping-pong) storage for the Q distribution
//                channels of an LBM lattice. The solver reads all Q channels of
//                a cell from the current buffer (bank_sel) and writes masked
//                channels to the next buffer (~bank_sel). A swap flips the two
//                buffers at step boundaries. The block also provides a
//                hardware init-fill of both buffers, a host read port that
//                yields to the solver, and sticky out-of-range detection.
//
//  Ports       : clk, rst                 clock, synchronous active-high reset
//                init_start/init_val      start fill of both buffers
//                init_busy, ready         fill in progress / normal operation
//                rd_en/rd_addr            solver read  -> rd_data/rd_valid (+1)
//                wr_en/wr_addr/wr_data    solver masked write (wr_mask)
//                swap_req -> swap_ack     buffer flip, bank_sel = read buffer
//                host_req/host_addr       host read, host_grant (comb),
//                                         host_data/host_valid (+1)
//                oob_err                  sticky out-of-range access flag
//  Revision    : 1.0  initial release
// ============================================================================
module lbm_dist_bank #(
    parameter int Q          = 9,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2500,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_start,
    input  logic [Q*DATA_WIDTH-1:0]  init_val,
    output logic                     init_busy,
    output logic                     ready,
    input  logic                     rd_en,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    output logic [Q*DATA_WIDTH-1:0]  rd_data,
    output logic                     rd_valid,
    input  logic                     wr_en,
    input  logic [ADDR_WIDTH-1:0]    wr_addr,
    input  logic [Q*DATA_WIDTH-1:0]  wr_data,
    input  logic [Q-1:0]             wr_mask,
    input  logic                     swap_req,
    output logic                     swap_ack,
    output logic                     bank_sel,
    input  logic                     host_req,
    input  logic [ADDR_WIDTH-1:0]    host_addr,
    output logic                     host_grant,
    output logic [Q*DATA_WIDTH-1:0]  host_data,
    output logic                     host_valid,
    output logic                     oob_err
);

    localparam int                    c_w         = Q * DATA_WIDTH;
    // DEPTH widened by one bit so that DEPTH == 2**ADDR_WIDTH still compares correctly
    localparam logic [ADDR_WIDTH:0]   c_depth_ext = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    // Buffer storage; contents are intentionally not reset.
    logic [c_w-1:0] r_buf0 [DEPTH];
    logic [c_w-1:0] r_buf1 [DEPTH];

    state_t                r_state_q,      w_state_d;
    logic [ADDR_WIDTH-1:0] r_cnt_q,        w_cnt_d;
    logic                  r_bank_q,       w_bank_d;
    logic [c_w-1:0]        r_rd_data_q,    w_rd_data_d;
    logic                  r_rd_valid_q,   w_rd_valid_d;
    logic [c_w-1:0]        r_host_data_q,  w_host_data_d;
    logic                  r_host_valid_q, w_host_valid_d;
    logic                  r_swap_ack_q,   w_swap_ack_d;
    logic                  r_oob_q,        w_oob_d;

    logic                  w_is_ready;
    logic                  w_is_init;
    logic                  w_rd_in;
    logic                  w_host_in;
    logic                  w_wr_in;
    logic                  w_host_grant;
    logic [c_w-1:0]        w_rd_word;
    logic [c_w-1:0]        w_host_word;
    logic                  w_we0;
    logic                  w_we1;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [c_w-1:0]        w_wr_data;
    logic [Q-1:0]          w_wr_mask;

    always_comb begin
        w_is_ready   = (r_state_q == ST_READY);
        w_is_init    = (r_state_q == ST_INIT);
        w_rd_in      = ({1'b0, rd_addr}   < c_depth_ext);
        w_host_in    = ({1'b0, host_addr} < c_depth_ext);
        w_wr_in      = ({1'b0, wr_addr}   < c_depth_ext);
        // Solver reads take priority over the host port.
        w_host_grant = host_req && w_is_ready && !rd_en && !rst;

        // Out-of-range words are forced to zero below, so the raw array read
        // is only consumed when the index is legal.
        w_rd_word    = r_bank_q ? r_buf1[rd_addr]   : r_buf0[rd_addr];
        w_host_word  = r_bank_q ? r_buf1[host_addr] : r_buf0[host_addr];

        // Single write port per buffer, shared by init-fill and solver writes.
        w_wr_addr    = w_is_init ? r_cnt_q : wr_addr;
        w_wr_data    = w_is_init ? init_val : wr_data;
        w_wr_mask    = w_is_init ? {Q{1'b1}} : wr_mask;
        w_we0        = !rst && (w_is_init || (w_is_ready && wr_en && w_wr_in &&  r_bank_q));
        w_we1        = !rst && (w_is_init || (w_is_ready && wr_en && w_wr_in && !r_bank_q));

        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        w_bank_d       = r_bank_q;
        w_rd_data_d    = r_rd_data_q;
        w_rd_valid_d   = 1'b0;
        w_host_data_d  = r_host_data_q;
        w_host_valid_d = 1'b0;
        w_swap_ack_d   = 1'b0;
        w_oob_d        = r_oob_q;

        case (r_state_q)
            ST_IDLE: begin
                if (init_start) begin
                    w_state_d = ST_INIT;
                    w_cnt_d   = '0;
                end
            end
            ST_INIT: begin
                if (r_cnt_q == c_last_addr) begin
                    w_state_d = ST_READY;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d   = r_cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (rd_en) begin
                    w_rd_valid_d = 1'b1;
                    w_rd_data_d  = w_rd_in ? w_rd_word : '0;
                    if (!w_rd_in) w_oob_d = 1'b1;
                end
                if (w_host_grant) begin
                    w_host_valid_d = 1'b1;
                    w_host_data_d  = w_host_in ? w_host_word : '0;
                    if (!w_host_in) w_oob_d = 1'b1;
                end
                if (wr_en && !w_wr_in) w_oob_d = 1'b1;
                if (swap_req) begin
                    w_bank_d     = ~r_bank_q;
                    w_swap_ack_d = 1'b1;
                end
                if (init_start) begin
                    w_state_d = ST_INIT;
                    w_cnt_d   = '0;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_cnt_q        <= '0;
            r_bank_q       <= 1'b0;
            r_rd_data_q    <= '0;
            r_rd_valid_q   <= 1'b0;
            r_host_data_q  <= '0;
            r_host_valid_q <= 1'b0;
            r_swap_ack_q   <= 1'b0;
            r_oob_q        <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_bank_q       <= w_bank_d;
            r_rd_data_q    <= w_rd_data_d;
            r_rd_valid_q   <= w_rd_valid_d;
            r_host_data_q  <= w_host_data_d;
            r_host_valid_q <= w_host_valid_d;
            r_swap_ack_q   <= w_swap_ack_d;
            r_oob_q        <= w_oob_d;
        end
    end

    // Per-channel masked writes into both buffers.
    always_ff @(posedge clk) begin
        for (int k = 0; k < Q; k++) begin
            if (w_we0 && w_wr_mask[k])
                r_buf0[w_wr_addr][k*DATA_WIDTH +: DATA_WIDTH] <= w_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            if (w_we1 && w_wr_mask[k])
                r_buf1[w_wr_addr][k*DATA_WIDTH +: DATA_WIDTH] <= w_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign init_busy  = w_is_init;
    assign ready      = w_is_ready;
    assign rd_data    = r_rd_data_q;
    assign rd_valid   = r_rd_valid_q;
    assign swap_ack   = r_swap_ack_q;
    assign bank_sel   = r_bank_q;
    assign host_grant = w_host_grant;
    assign host_data  = r_host_data_q;
    assign host_valid = r_host_valid_q;
    assign oob_err    = r_oob_q;

endmodule
`default_nettype wire

// File: tb/tb_lbm_dist_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lbm_dist_bank
//  Description : Self-checking bench for lbm_dist_bank (Q=9, DEPTH=16).
//                Directed scenarios with literal expectations, then random
//                traffic compared every cycle against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lbm_dist_bank;

    localparam int c_q  = 9;
    localparam int c_dw = 16;
    localparam int c_d  = 16;
    localparam int c_aw = 5;
    localparam int c_w  = c_q * c_dw;

    logic             clk = 1'b0;
    logic             rst;
    logic             init_start;
    logic [c_w-1:0]   init_val;
    logic             init_busy, ready;
    logic             rd_en;
    logic [c_aw-1:0]  rd_addr;
    logic [c_w-1:0]   rd_data;
    logic             rd_valid;
    logic             wr_en;
    logic [c_aw-1:0]  wr_addr;
    logic [c_w-1:0]   wr_data;
    logic [c_q-1:0]   wr_mask;
    logic             swap_req, swap_ack, bank_sel;
    logic             host_req;
    logic [c_aw-1:0]  host_addr;
    logic             host_grant;
    logic [c_w-1:0]   host_data;
    logic             host_valid;
    logic             oob_err;

    lbm_dist_bank #(.Q(c_q), .DATA_WIDTH(c_dw), .DEPTH(c_d), .ADDR_WIDTH(c_aw)) dut (
        .clk(clk), .rst(rst),
        .init_start(init_start), .init_val(init_val),
        .init_busy(init_busy), .ready(ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .swap_req(swap_req), .swap_ack(swap_ack), .bank_sel(bank_sel),
        .host_req(host_req), .host_addr(host_addr), .host_grant(host_grant),
        .host_data(host_data), .host_valid(host_valid),
        .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [c_w-1:0] act, input logic [c_w-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_mode: 0 idle, 1 filling, 2 ready
    int             m_mode = 0;
    int             m_fill = 0;
    int             m_bank = 0;
    bit             m_oob  = 0;
    logic [c_w-1:0] m_mem [2][c_d];
    logic [c_w-1:0] m_rd_data = '0;
    bit             m_rd_valid = 0;
    logic [c_w-1:0] m_host_data = '0;
    bit             m_host_valid = 0;
    bit             m_ack = 0;

    always @(posedge clk) begin
        int cur, nxt;
        if (rst) begin
            m_mode = 0; m_fill = 0; m_bank = 0; m_oob = 0;
            m_rd_data = '0; m_rd_valid = 0; m_host_data = '0; m_host_valid = 0; m_ack = 0;
        end else begin
            m_rd_valid = 0; m_host_valid = 0; m_ack = 0;
            cur = m_bank; nxt = 1 - m_bank;
            if (m_mode == 0) begin
                if (init_start) begin m_mode = 1; m_fill = 0; end
            end else if (m_mode == 1) begin
                m_mem[0][m_fill] = init_val;
                m_mem[1][m_fill] = init_val;
                m_fill++;
                if (m_fill == c_d) begin m_mode = 2; m_fill = 0; end
            end else begin
                if (rd_en) begin
                    m_rd_valid = 1;
                    if (int'(rd_addr) < c_d) m_rd_data = m_mem[cur][rd_addr];
                    else begin m_rd_data = '0; m_oob = 1; end
                end else if (host_req) begin
                    m_host_valid = 1;
                    if (int'(host_addr) < c_d) m_host_data = m_mem[cur][host_addr];
                    else begin m_host_data = '0; m_oob = 1; end
                end
                if (wr_en) begin
                    if (int'(wr_addr) < c_d) begin
                        for (int k = 0; k < c_q; k++)
                            if (wr_mask[k]) m_mem[nxt][wr_addr][k*c_dw +: c_dw] = wr_data[k*c_dw +: c_dw];
                    end else m_oob = 1;
                end
                if (swap_req) begin m_bank = nxt; m_ack = 1; end
                if (init_start) begin m_mode = 1; m_fill = 0; end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("init_busy",  c_w'(init_busy),  c_w'(m_mode == 1));
            check("ready",      c_w'(ready),      c_w'(m_mode == 2));
            check("rd_valid",   c_w'(rd_valid),   c_w'(m_rd_valid));
            check("rd_data",    rd_data,          m_rd_data);
            check("host_valid", c_w'(host_valid), c_w'(m_host_valid));
            check("host_data",  host_data,        m_host_data);
            check("swap_ack",   c_w'(swap_ack),   c_w'(m_ack));
            check("bank_sel",   c_w'(bank_sel),   c_w'(m_bank));
            check("oob_err",    c_w'(oob_err),    c_w'(m_oob));
            check("host_grant", c_w'(host_grant), c_w'(host_req && m_mode == 2 && !rd_en && !rst));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        init_start = 0; rd_en = 0; wr_en = 0; swap_req = 0; host_req = 0;
        rd_addr = '0; wr_addr = '0; host_addr = '0; wr_mask = '0; wr_data = '0;
    endtask

    task automatic do_read(input logic [c_aw-1:0] a);
        rd_en = 1; rd_addr = a;
        cycle();
        rd_en = 0;
    endtask

    task automatic do_fill(output int n);
        init_start = 1;
        cycle();
        init_start = 0;
        n = 0;
        while (init_busy && n < 100) begin
            n++;
            cycle();
        end
    endtask

    function automatic logic [c_w-1:0] rep(input logic [c_dw-1:0] v);
        logic [c_w-1:0] r;
        for (int k = 0; k < c_q; k++) r[k*c_dw +: c_dw] = v;
        return r;
    endfunction

    logic [c_w-1:0] init_vec;
    logic [c_w-1:0] exp_vec;
    int             n_busy;

    initial begin
        for (int k = 0; k < c_q; k++) init_vec[k*c_dw +: c_dw] = 16'h0100 + 16'(k);
        idle_inputs();
        init_val = init_vec;
        rst = 1;
        cycle();
        cycle();
        cmp_en = 1;
        check("reset_ready", c_w'(ready), '0);
        check("reset_busy",  c_w'(init_busy), '0);
        rst = 0;

        // init fill: busy exactly DEPTH cycles
        do_fill(n_busy);
        check("busy_cycles", c_w'(n_busy), c_w'(16));
        check("ready_after_init", c_w'(ready), c_w'(1));

        do_read(5'd0);
        check("rd0_valid", c_w'(rd_valid), c_w'(1));
        check("rd0_data",  rd_data, init_vec);
        do_read(5'd15);
        check("rd15_data", rd_data, init_vec);
        cycle();
        check("rd_valid_pulse", c_w'(rd_valid), '0);
        check("rd_data_hold", rd_data, init_vec);

        // full write to next buffer, visible only after swap
        wr_en = 1; wr_addr = 5'd5; wr_data = rep(16'h7FFF); wr_mask = 9'h1FF;
        cycle();
        wr_en = 0;
        do_read(5'd5);
        check("rd5_preswap", rd_data, init_vec);
        swap_req = 1;
        cycle();
        swap_req = 0;
        check("bank_after_swap", c_w'(bank_sel), c_w'(1));
        check("swap_ack_pulse",  c_w'(swap_ack), c_w'(1));
        cycle();
        check("swap_ack_clear",  c_w'(swap_ack), '0);
        do_read(5'd5);
        check("rd5_postswap", rd_data, rep(16'h7FFF));

        // masked write: only channel 2
        wr_en = 1; wr_addr = 5'd3; wr_data = rep(16'hAAAA); wr_mask = 9'h004;
        cycle();
        wr_en = 0;
        swap_req = 1;
        cycle();
        swap_req = 0;
        do_read(5'd3);
        exp_vec = init_vec;
        exp_vec[2*c_dw +: c_dw] = 16'hAAAA;
        check("rd3_masked", rd_data, exp_vec);

        // host waits while the solver reads
        host_req = 1; host_addr = 5'd7;
        rd_en = 1; rd_addr = 5'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("grant_blocked", c_w'(host_grant), '0);
            cycle();
        end
        rd_en = 0;
        #1;
        check("grant_free", c_w'(host_grant), c_w'(1));
        cycle();
        host_req = 0;
        check("host_valid", c_w'(host_valid), c_w'(1));
        check("host_data7", host_data, init_vec);

        // out of range accesses
        do_read(5'd16);
        check("oob_rd_valid", c_w'(rd_valid), c_w'(1));
        check("oob_rd_data",  rd_data, '0);
        check("oob_flag",     c_w'(oob_err), c_w'(1));
        wr_en = 1; wr_addr = 5'd20; wr_data = rep(16'hFFFF); wr_mask = 9'h1FF;
        cycle();
        wr_en = 0;
        swap_req = 1;
        cycle();
        swap_req = 0;
        do_read(5'd4);
        check("oob_wr_dropped", rd_data, init_vec);
        cycle();
        check("oob_sticky", c_w'(oob_err), c_w'(1));

        // reset in the middle of a fill
        init_start = 1;
        cycle();
        init_start = 0;
        repeat (8) cycle();
        rst = 1; host_req = 1;
        cycle();
        rst = 0;
        check("rst_busy",   c_w'(init_busy), '0);
        check("rst_ready",  c_w'(ready), '0);
        check("rst_bank",   c_w'(bank_sel), '0);
        check("rst_oob",    c_w'(oob_err), '0);
        check("rst_rddata", rd_data, '0);
        check("rst_hdata",  host_data, '0);
        check("rst_grant",  c_w'(host_grant), '0);
        host_req = 0;
        swap_req = 1;
        cycle();
        swap_req = 0;
        check("idle_no_ack",  c_w'(swap_ack), '0);
        check("idle_no_swap", c_w'(bank_sel), '0);

        do_fill(n_busy);
        check("refill_cycles", c_w'(n_busy), c_w'(16));

        // random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            rst        = ($urandom % 500) == 0;
            init_start = ($urandom % 48) == 0;
            if (($urandom % 50) == 0)
                for (int k = 0; k < c_q; k++) init_val[k*c_dw +: c_dw] = 16'($urandom);
            rd_en      = $urandom % 2;
            rd_addr    = (($urandom % 12) == 0) ? 5'(16 + $urandom % 16) : 5'($urandom % 16);
            host_req   = $urandom % 2;
            host_addr  = (($urandom % 12) == 0) ? 5'(16 + $urandom % 16) : 5'($urandom % 16);
            wr_en      = $urandom % 2;
            wr_addr    = (($urandom % 12) == 0) ? 5'(16 + $urandom % 16) : 5'($urandom % 16);
            for (int k = 0; k < c_q; k++) wr_data[k*c_dw +: c_dw] = 16'($urandom);
            wr_mask    = 9'($urandom);
            swap_req   = ($urandom % 6) == 0;
            cycle();
        end
        idle_inputs();
        cycle();
        cmp_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
